fpir_to_ieee_converter: RTL
===========================

FPIR_TO_IEEE_CONVERTER -- requirements
Module: fpir_to_ieee_converter

Interface
REQ-001 The block SHALL have the parameter BW_IEEE_EXPONENT, default 8, meaning the IEEE exponent width.
REQ-002 The block SHALL have the parameter BW_IEEE_MANTISSA, default 23, meaning the IEEE stored fraction width.
REQ-003 The block SHALL have the parameter BW_EXPONENT_EXTENDED, default 10, meaning the FPIR two's-complement unbiased exponent width ({overflow,exponent} fields).
REQ-004 The block SHALL have the parameter BW_GUARD, default 3, meaning the FPIR guard bits {G,R,S}, where S is sticky.
REQ-005 The block SHALL derive BW_SIGNIFICAND_EXTENDED = BW_IEEE_MANTISSA+1+BW_GUARD (27) and BW_FPIR_VALUE = `BW_FPIR_TYPE+1+BW_EXPONENT_EXTENDED+BW_SIGNIFICAND_EXTENDED.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Port clk  input  1  clock, all state on rising edge.
REQ-008 Port rstnn  input  1  asynchronous active-low reset.
REQ-009 Port in_valid  input  1  FPIR operand present.
REQ-010 Port in_ready  output  1  block accepts the operand this cycle.
REQ-011 Port in_value  input  BW_FPIR_VALUE  {type,sign,exponent,significand+guard}; a NORMAL significand has its leading 1 at the MSB.
REQ-012 Port out_valid  output  1  IEEE result present.
REQ-013 Port out_ready  input  1  consumer takes the result.
REQ-014 Port out_value  output  1+BW_IEEE_EXPONENT+BW_IEEE_MANTISSA  IEEE result {sign,exp,frac}.
REQ-015 Port out_flags  output  3  {overflow,underflow,inexact} aligned with out_value.

Function
REQ-016 The pipeline SHALL have two register stages: S1 (decode and denormalize) and S2 (round, pack and output register).
REQ-017 S2 SHALL load when ~out_valid | out_ready; S1 SHALL load when ~s1_valid | s2_load; in_ready SHALL equal ~s1_valid | s2_load, combinationally.
REQ-018 The operand accepted at edge N SHALL appear at edge N+2 when there is no stall; throughput SHALL be 1 per cycle; the block SHALL not drop or duplicate operands under any out_ready pattern.
REQ-019 While out_valid=1 and out_ready=0, out_value and out_flags SHALL hold stable.
REQ-020 S1 SHALL compute biased exponent be = exponent + (2^(BW_IEEE_EXPONENT-1)-1) at BW_EXPONENT_EXTENDED+1 bits, signed.
REQ-021 If be<=0, S1 SHALL right-shift the significand by min(1-be, BW_IEEE_MANTISSA+3), OR all shifted-out bits into S, and set the exponent field to 0.
REQ-022 S2 SHALL round to nearest even: increment when G & (R|S|lsb).
REQ-023 A mantissa carry out of rounding SHALL increment the exponent field; this covers subnormal-to-minimum-normal promotion.
REQ-024 If be >= all-ones exponent, or rounding reaches it, the result SHALL be signed infinity with overflow=1 and inexact=1.
REQ-025 underflow SHALL be 1 when the result is subnormal or zero-by-rounding and inexact=1.
REQ-026 inexact SHALL be 1 when any of G, R or S is nonzero after denormalization.
REQ-027 Special input types SHALL pass through with flags 0: NAN gives canonical quiet NaN {0, all-ones exponent, 1 at the fraction MSB}; PZERO/MZERO give ±0; PINF/MINF give ±inf.
REQ-028 For special types the sign SHALL come from the type code, not the sign field.
REQ-029 An unknown type code SHALL be treated as NAN.

Reset
REQ-030 While rstnn=0: s1_valid=0, out_valid=0, out_value=0, out_flags=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands; the first accept after release produces the first output.

Verification
REQ-032 NORMAL sign 0, exp 0, sig 1<<26, guard 0 -> 0x3F800000, flags 000, two cycles after accept.
REQ-033 NORMAL exp +128 -> 0x7F800000, flags 101; exp -127, sig 1<<26 -> 0x00400000, flags 000; exp -160 -> 0x00000000, flags 011.
REQ-034 RNE ties: mantissa lsb 0 with guard 100 -> unchanged, inexact=1; lsb 1 with guard 100 -> +1 ulp; all-ones mantissa with guard 110 at exp 127 -> 0x7F800000, overflow=1.
REQ-035 Types NAN, MZERO and MINF -> 0x7FC00000, 0x80000000 and 0xFF800000 respectively, flags 000.
REQ-036 Back-to-back 8 operands with out_ready toggling in a random pattern -> in-order outputs matching a reference model, no loss, outputs held stable during stalls.
REQ-037 Assert rstnn low with two operands in flight -> out_valid=0 immediately; after release, no stale outputs appear.

Source files
------------

// File: rtl/fpir_to_ieee_converter_if.sv
// Handshake bundle between an FPIR producer and the IEEE converter.
// master drives the operand side and out_ready; slave is the converter.
`timescale 1ns/1ps
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`endif

interface fpir_to_ieee_converter_if #(
  parameter int BW_IEEE_EXPONENT     = 8,
  parameter int BW_IEEE_MANTISSA     = 23,
  parameter int BW_EXPONENT_EXTENDED = 10,
  parameter int BW_GUARD             = 3
);
  localparam int BW_SIGNIFICAND_EXTENDED = BW_IEEE_MANTISSA + 1 + BW_GUARD;
  localparam int BW_FPIR_VALUE = `BW_FPIR_TYPE + 1 + BW_EXPONENT_EXTENDED + BW_SIGNIFICAND_EXTENDED;
  localparam int BW_IEEE_VALUE = 1 + BW_IEEE_EXPONENT + BW_IEEE_MANTISSA;

  logic                     in_valid;
  logic                     in_ready;
  logic [BW_FPIR_VALUE-1:0] in_value;
  logic                     out_valid;
  logic                     out_ready;
  logic [BW_IEEE_VALUE-1:0] out_value;
  logic [2:0]               out_flags;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_value, out_flags
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_value, out_flags
  );
endinterface

// File: rtl/fpir_to_ieee_converter.sv
// FPIR -> IEEE-754 converter, two register stages.
// S1 decodes the type, biases the exponent and denormalizes tiny values;
// S2 rounds to nearest even, packs the word and holds it until taken.
// Type codes: 0 NORMAL, 1 PZERO, 2 MZERO, 3 PINF, 4 MINF, 5 NAN, others NAN.
`timescale 1ns/1ps
`ifndef BW_FPIR_TYPE
`define BW_FPIR_TYPE 3
`endif

module fpir_to_ieee_converter #(
  parameter int BW_IEEE_EXPONENT     = 8,
  parameter int BW_IEEE_MANTISSA     = 23,
  parameter int BW_EXPONENT_EXTENDED = 10,
  parameter int BW_GUARD             = 3
) (
  input logic                    clk,
  input logic                    rstnn,
  fpir_to_ieee_converter_if.slave bus
);
  localparam int BW_SIGNIFICAND_EXTENDED = BW_IEEE_MANTISSA + 1 + BW_GUARD;
  localparam int BW_FPIR_VALUE = `BW_FPIR_TYPE + 1 + BW_EXPONENT_EXTENDED + BW_SIGNIFICAND_EXTENDED;
  localparam int BW_TYPE  = `BW_FPIR_TYPE;
  localparam int BW_E     = BW_IEEE_EXPONENT;
  localparam int BW_M     = BW_IEEE_MANTISSA;
  localparam int BW_SE    = BW_SIGNIFICAND_EXTENDED;
  localparam int BW_EE    = BW_EXPONENT_EXTENDED;
  localparam int BW_BE    = BW_EE + 1;
  localparam int BW_IEEE  = 1 + BW_E + BW_M;
  localparam int MAX_SHIFT = BW_M + 3;
  localparam int BW_SH    = $clog2(MAX_SHIFT + 1);

  localparam logic [BW_TYPE-1:0] TYPE_NORMAL = BW_TYPE'(0);
  localparam logic [BW_TYPE-1:0] TYPE_PZERO  = BW_TYPE'(1);
  localparam logic [BW_TYPE-1:0] TYPE_MZERO  = BW_TYPE'(2);
  localparam logic [BW_TYPE-1:0] TYPE_PINF   = BW_TYPE'(3);
  localparam logic [BW_TYPE-1:0] TYPE_MINF   = BW_TYPE'(4);

  localparam logic signed [BW_BE-1:0] BIAS         = BW_BE'((1 << (BW_E - 1)) - 1);
  localparam logic signed [BW_BE-1:0] BE_ONE       = BW_BE'(1);
  localparam logic signed [BW_BE-1:0] BE_MAX_SHIFT = BW_BE'(MAX_SHIFT);
  localparam logic signed [BW_BE-1:0] BE_EXP_ONES  = BW_BE'((1 << BW_E) - 1);

  localparam logic [BW_E-1:0]    EXP_ONES = '1;
  localparam logic [BW_IEEE-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(BW_M-1){1'b0}}};
  localparam logic [BW_IEEE-1:0] POS_INF  = {1'b0, EXP_ONES, {BW_M{1'b0}}};
  localparam logic [BW_IEEE-1:0] NEG_INF  = {1'b1, EXP_ONES, {BW_M{1'b0}}};
  localparam logic [BW_IEEE-1:0] NEG_ZERO = {1'b1, {(BW_E+BW_M){1'b0}}};

  // Operand fields
  logic [BW_TYPE-1:0]      in_type;
  logic                    in_sign;
  logic signed [BW_EE-1:0] in_exp;
  logic [BW_SE-1:0]        in_sig;
  logic [BW_FPIR_VALUE-1:0] in_word;

  assign in_word = bus.in_value;
  assign {in_type, in_sign, in_exp, in_sig} = in_word;

  // Pipeline state
  logic                 s1_valid_reg;
  logic                 s1_sign_reg;
  logic                 s1_special_reg;
  logic [BW_IEEE-1:0]   s1_special_value_reg;
  logic                 s1_overflow_reg;
  logic [BW_E-1:0]      s1_exp_reg;
  logic [BW_SE-2:0]     s1_sig_reg;
  logic                 out_valid_reg;
  logic [BW_IEEE-1:0]   out_value_reg;
  logic [2:0]           out_flags_reg;

  logic s1_load, s2_load;

  assign s2_load      = ~out_valid_reg | bus.out_ready;
  assign s1_load      = ~s1_valid_reg | s2_load;
  assign bus.in_ready = s1_load;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_value = out_value_reg;
  assign bus.out_flags = out_flags_reg;

  // Biased exponent and denormalizing shift (capped; beyond the cap only sticky matters)
  logic signed [BW_BE-1:0] be, sh_raw;
  logic [BW_SH-1:0]        sh;
  logic [BW_SE-2:0]        shifted_sig;
  logic [BW_SE-1:0]        lost_mask;
  logic [BW_SE-2:0]        denorm_sig;

  assign be          = $signed({in_exp[BW_EE-1], in_exp}) + BIAS;
  assign sh_raw      = BE_ONE - be;
  assign sh          = (sh_raw > BE_MAX_SHIFT) ? BW_SH'(MAX_SHIFT) : sh_raw[BW_SH-1:0];
  assign shifted_sig = (BW_SE-1)'(in_sig >> sh);
  assign lost_mask   = ~({BW_SE{1'b1}} << sh);
  assign denorm_sig  = {shifted_sig[BW_SE-2:1], shifted_sig[0] | (|(in_sig & lost_mask))};

  logic                 dec_special;
  logic [BW_IEEE-1:0]   dec_special_value;
  logic                 dec_overflow;
  logic [BW_E-1:0]      dec_exp;
  logic [BW_SE-2:0]     dec_sig;

  // S1 decode: specials become a finished word, normals get exponent/significand
  always_comb begin
    dec_special       = 1'b1;
    dec_special_value = QNAN;
    dec_overflow      = 1'b0;
    dec_exp           = '0;
    dec_sig           = in_sig[BW_SE-2:0];
    case (in_type)
      TYPE_NORMAL: begin
        dec_special = 1'b0;
        if (be >= BE_EXP_ONES) begin
          dec_overflow = 1'b1;
        end else if (be < BE_ONE) begin
          dec_sig = denorm_sig;
        end else begin
          dec_exp = be[BW_E-1:0];
        end
      end
      TYPE_PZERO: dec_special_value = '0;
      TYPE_MZERO: dec_special_value = NEG_ZERO;
      TYPE_PINF:  dec_special_value = POS_INF;
      TYPE_MINF:  dec_special_value = NEG_INF;
      default:    dec_special_value = QNAN;
    endcase
  end

  // S1 register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      s1_valid_reg         <= 1'b0;
      s1_sign_reg          <= 1'b0;
      s1_special_reg       <= 1'b0;
      s1_special_value_reg <= '0;
      s1_overflow_reg      <= 1'b0;
      s1_exp_reg           <= '0;
      s1_sig_reg           <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_reg          <= in_sign;
        s1_special_reg       <= dec_special;
        s1_special_value_reg <= dec_special_value;
        s1_overflow_reg      <= dec_overflow;
        s1_exp_reg           <= dec_exp;
        s1_sig_reg           <= dec_sig;
      end
    end
  end

  // S2 rounding: a fraction carry ripples into the exponent field naturally
  logic [BW_M-1:0]      frac;
  logic                 g_bit, r_bit, s_bit, inc, inexact;
  logic [BW_E+BW_M-1:0] rounded;
  logic                 rnd_overflow;
  logic [BW_IEEE-1:0]   res_value;
  logic [2:0]           res_flags;

  assign frac    = s1_sig_reg[BW_GUARD +: BW_M];
  assign g_bit   = s1_sig_reg[BW_GUARD-1];
  assign r_bit   = s1_sig_reg[BW_GUARD-2];
  assign s_bit   = |s1_sig_reg[BW_GUARD-3:0];
  assign inc     = g_bit & (r_bit | s_bit | frac[0]);
  assign inexact = g_bit | r_bit | s_bit;
  assign rounded = {s1_exp_reg, frac} + {{(BW_E+BW_M-1){1'b0}}, inc};
  assign rnd_overflow = &rounded[BW_E+BW_M-1:BW_M];

  // S2 result selection: special pass-through, overflow to infinity, or rounded value
  always_comb begin
    res_value = {s1_sign_reg, rounded};
    res_flags = {1'b0, (rounded[BW_E+BW_M-1:BW_M] == '0) & inexact, inexact};
    if (s1_special_reg) begin
      res_value = s1_special_value_reg;
      res_flags = 3'b000;
    end else if (s1_overflow_reg | rnd_overflow) begin
      res_value = {s1_sign_reg, EXP_ONES, {BW_M{1'b0}}};
      res_flags = 3'b101;
    end
  end

  // S2 output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      out_valid_reg <= 1'b0;
      out_value_reg <= '0;
      out_flags_reg <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_value_reg <= res_value;
        out_flags_reg <= res_flags;
      end
    end
  end
endmodule
